spi_master_param: RTL

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// Parameterised SPI master: CPOL/CPHA per transfer, one-hot active-low chip selects, registered SCLK.
// Define SPI_LSB_FIRST_EN to add the lsbFirst input (per-transfer LSB-first shifting); otherwise always MSB first.
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int CLK_DIV    = 1,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SW-1:0]         slaveSelect,
    input  logic                  cpol,
    input  logic                  cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  lsbFirst,
`endif
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic [NUM_SLAVES-1:0] CS,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [2:0]            fsm_state
);

    localparam int HW = $clog2(2 * DATA_WIDTH);
    localparam int IW = HW - 1;
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_WIDTH - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         div_cnt;
    logic [HW-1:0]         half_cnt;
    logic [HW-1:0]         edge_half;
    logic [IW-1:0]         edge_bit;
    logic [DATA_WIDTH-1:0] tx_q, rx_q;
    logic                  cpol_q, cpha_q, lsb_q, lsb_in;
    logic                  accept, div_wrap, edge_fire;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsbFirst;
`else
    assign lsb_in = 1'b0;
`endif

    // Bit k of the serial stream maps to word position k (LSB first) or DATA_WIDTH-1-k.
    function automatic logic [IW-1:0] bit_pos(input logic [IW-1:0] k, input logic lsb);
        return lsb ? k : (LAST_BIT - k);
    endfunction

    assign accept    = (state == IDLE) && start && (int'(slaveSelect) < NUM_SLAVES);
    assign div_wrap  = (div_cnt == DIV_LAST);
    assign busy      = (state == SETUP) || (state == TRANSFER) || (state == HOLD);
    assign done      = (state == DONE);
    assign fsm_state = state;
    assign edge_bit  = edge_half[HW-1:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // edge_fire marks the clk edge on which SCLK enters half-period edge_half (even = leading).
    always_comb begin
        state_next = state;
        edge_fire  = 1'b0;
        edge_half  = '0;
        case (state)
            IDLE:     if (accept) state_next = SETUP;
            SETUP:    if (div_wrap) begin
                          state_next = TRANSFER;
                          edge_fire  = 1'b1;
                      end
            TRANSFER: if (div_wrap) begin
                          if (half_cnt == LAST_HALF) begin
                              state_next = HOLD;
                          end else begin
                              edge_fire = 1'b1;
                              edge_half = half_cnt + 1'b1;
                          end
                      end
            HOLD:     if (div_wrap) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt            <= '0;
            half_cnt           <= '0;
            tx_q               <= '0;
            rx_q               <= '0;
            cpol_q             <= 1'b0;
            cpha_q             <= 1'b0;
            lsb_q              <= 1'b0;
            SCLK               <= 1'b0;
            MOSI               <= 1'b0;
            CS                 <= '1;
            masterDataReceived <= '0;
        end else begin
            if (state_next != state || div_wrap) div_cnt <= '0;
            else                                 div_cnt <= div_cnt + 1'b1;

            if (edge_fire) half_cnt <= edge_half;

            if (accept) begin
                tx_q   <= masterDataToSend;
                rx_q   <= '0;
                cpol_q <= cpol;
                cpha_q <= cpha;
                lsb_q  <= lsb_in;
                SCLK   <= cpol;
                MOSI   <= lsb_in ? masterDataToSend[0] : masterDataToSend[DATA_WIDTH-1];
                CS     <= ~(NUM_SLAVES'(1) << slaveSelect);
            end

            if (edge_fire) begin
                SCLK <= cpol_q ^ ~edge_half[0];
                if (!edge_half[0]) begin
                    // Leading edge: sample (cpha=0) or present bit k (cpha=1; bit 0 already out from SETUP).
                    if (!cpha_q)                 rx_q[bit_pos(edge_bit, lsb_q)] <= MISO;
                    else if (edge_bit != '0)     MOSI <= tx_q[bit_pos(edge_bit, lsb_q)];
                end else begin
                    if (cpha_q)                  rx_q[bit_pos(edge_bit, lsb_q)] <= MISO;
                    else if (edge_bit != LAST_BIT) MOSI <= tx_q[bit_pos(edge_bit + 1'b1, lsb_q)];
                end
            end

            if (state == TRANSFER && state_next == HOLD) SCLK <= cpol_q;

            if (state == HOLD && state_next == DONE) begin
                CS                 <= '1;
                masterDataReceived <= rx_q;
            end
        end
    end

endmodule
